// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit drain.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    BACKOFF,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DefaultClocksPerBit = 434;

  // Start bit + 8 data bits + stop bit for a byte-wide word.
  localparam int FrameBits = 10;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read handshake between the byte ring buffer (slave) and the TX drain (master).
interface uart_tx_drain_if #(
  parameter int WordSize = 8
) ();

  logic                dataReadEnable;
  logic                dataReadAck;
  logic [WordSize-1:0] dataRead;

  modport master (
    output dataReadEnable,
    input  dataReadAck,
    input  dataRead
  );

  modport slave (
    input  dataReadEnable,
    output dataReadAck,
    output dataRead
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running baud counter; bitDone marks the last clock of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int ClocksPerBit = DefaultClocksPerBit
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitDone
);

  localparam int BaudW = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClocksPerBit - 1);

  logic [BaudW-1:0] baud;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      baud <= '0;
    end else if (baud == BaudLast) begin
      baud <= '0;
    end else begin
      baud <= baud + 1'b1;
    end
  end

  assign bitDone = (baud == BaudLast);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the ring buffer and serialises them as 8N1, LSB first.
// A refused read backs off for RetryDelay cycles and retries; no byte is dropped.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int WordSize     = 8,
  parameter int ClocksPerBit = DefaultClocksPerBit,
  parameter int RetryDelay   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  uart_tx_drain_if.master        rd,
  output logic                   txd,
  output logic                   busy,
  output logic [31:0]            bytesSent
);

  localparam int BitW   = $clog2(WordSize + 1);
  localparam int RetryW = (RetryDelay > 1) ? $clog2(RetryDelay) : 1;

  tx_state_t           state, state_n;
  logic                txd_n;
  logic                dre_n;
  logic                busy_n;
  logic [31:0]         sent_n;
  logic [BitW-1:0]     bitCnt, bitCnt_n;
  logic [RetryW-1:0]   retry, retry_n;
  logic [WordSize-1:0] shift, shift_n;
  logic                bitDone;
  logic                timerClr;

  // The timer restarts on every state change, so each timed state sees whole bits.
  uart_bit_timer #(
    .ClocksPerBit (ClocksPerBit)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timerClr),
    .bitDone (bitDone)
  );

  always_comb begin
    state_n  = state;
    txd_n    = txd;
    sent_n   = bytesSent;
    bitCnt_n = bitCnt;
    retry_n  = retry;
    shift_n  = shift;

    unique case (state)
      IDLE: begin
        if (enable) state_n = REQ;
      end
      REQ: begin
        state_n = ACK;
      end
      ACK: begin
        if (rd.dataReadAck) begin
          shift_n = rd.dataRead;
          txd_n   = 1'b0;
          state_n = START;
        end else begin
          retry_n = RetryW'(RetryDelay - 1);
          state_n = BACKOFF;
        end
      end
      BACKOFF: begin
        if (retry == '0) state_n = IDLE;
        else             retry_n = retry - 1'b1;
      end
      START: begin
        if (bitDone) begin
          txd_n    = shift[0];
          bitCnt_n = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (bitDone) begin
          if (bitCnt == BitW'(WordSize - 1)) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            shift_n  = shift >> 1;
            txd_n    = shift[1];
            bitCnt_n = bitCnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (bitDone) begin
          sent_n  = bytesSent + 32'd1;
          state_n = enable ? REQ : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    dre_n    = (state_n == REQ);
    busy_n   = !((state_n == IDLE) || (state_n == BACKOFF));
    timerClr = (state_n != state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      txd               <= 1'b1;
      rd.dataReadEnable <= 1'b0;
      busy              <= 1'b0;
      bytesSent         <= '0;
      bitCnt            <= '0;
      retry             <= '0;
    end else begin
      state             <= state_n;
      txd               <= txd_n;
      rd.dataReadEnable <= dre_n;
      busy              <= busy_n;
      bytesSent         <= sent_n;
      bitCnt            <= bitCnt_n;
      retry             <= retry_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised and directed bench for uart_tx_drain: ring-buffer model, UART line
// decoder and frame-timing expectations derived from the 8N1 framing rules.
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int Cpb      = 4;
  localparam int Retry    = 16;
  localparam int FrameLen = FrameBits * Cpb;
  localparam int Gap      = FrameLen + 2;
  localparam int Period   = Retry + 3;
  localparam int Depth    = 4096;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        txd;
  logic        busy;
  logic [31:0] bytesSent;

  uart_tx_drain_if #(.WordSize(8)) rd ();

  uart_tx_drain #(
    .WordSize     (8),
    .ClocksPerBit (Cpb),
    .RetryDelay   (Retry)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rd        (rd),
    .txd       (txd),
    .busy      (busy),
    .bytesSent (bytesSent)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Ring buffer model: pops on request, refuses while forced collisions remain.
  logic [7:0] bmem [0:Depth-1];
  int bwp = 0;
  int brp = 0;
  int coll_req = 0;
  int coll_used = 0;

  always @(posedge clk) begin
    if (rd.dataReadEnable) begin
      if (coll_used < coll_req) begin
        rd.dataReadAck <= 1'b0;
        coll_used      <= coll_used + 1;
      end else if (brp != bwp) begin
        rd.dataReadAck <= 1'b1;
        rd.dataRead    <= bmem[brp % Depth];
        brp            <= brp + 1;
      end else begin
        rd.dataReadAck <= 1'b0;
      end
    end else begin
      rd.dataReadAck <= 1'b0;
    end
  end

  // Cycle index since reset release, and a posedge-aligned copy of reset.
  int   t = 0;
  logic in_rst = 1'b1;
  always @(posedge clk) begin
    in_rst <= reset;
    t      <= reset ? 0 : t + 1;
  end

  // Line monitor: records request and start-bit times, decodes frames mid-bit.
  logic       prev_txd = 1'b1;
  logic       prev_dre = 1'b0;
  logic       consec   = 1'b0;
  logic       rx_act   = 1'b0;
  logic [7:0] rx_sh    = 8'h00;
  int         rx_s     = 0;
  int         dre_n    = 0;
  int         fall_n   = 0;
  int         rx_n     = 0;
  int         ferr     = 0;
  int         dre_mem  [0:Depth-1];
  int         fall_mem [0:Depth-1];
  logic [7:0] rx_mem   [0:Depth-1];

  function automatic int bit_idx(input int now, input int s);
    return (now - s - 2) / Cpb;
  endfunction

  always @(negedge clk) begin
    if (in_rst) begin
      rx_act   <= 1'b0;
      prev_txd <= 1'b1;
      prev_dre <= 1'b0;
    end else begin
      prev_txd <= txd;
      prev_dre <= rd.dataReadEnable;
      if (rd.dataReadEnable && prev_dre) consec <= 1'b1;
      if (rd.dataReadEnable) begin
        dre_mem[dre_n % Depth] <= t;
        dre_n                  <= dre_n + 1;
      end
      if (!rx_act && prev_txd && !txd) begin
        rx_act                   <= 1'b1;
        rx_s                     <= t;
        fall_mem[fall_n % Depth] <= t;
        fall_n                   <= fall_n + 1;
      end else if (rx_act && ((t - rx_s - 2) % Cpb) == 0) begin
        if (bit_idx(t, rx_s) == 0) begin
          if (txd !== 1'b0) ferr <= ferr + 1;
        end else if (bit_idx(t, rx_s) <= 8) begin
          rx_sh[bit_idx(t, rx_s) - 1] <= txd;
        end else begin
          if (txd !== 1'b1) ferr <= ferr + 1;
          rx_mem[rx_n % Depth] <= rx_sh;
          rx_n                 <= rx_n + 1;
          rx_act               <= 1'b0;
        end
      end
    end
  end

  function automatic logic exp_txd(input logic [7:0] b, input int off);
    int idx;
    if (off < 0) return 1'b1;
    idx = off / Cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    bmem[bwp % Depth] = b;
    bwp++;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dre", rd.dataReadEnable, 0);
    check_eq("rst_sent", bytesSent, 0);
    reset = 1'b0;
  endtask

  task automatic wait_t(input int n);
    while (t < n) @(negedge clk);
  endtask

  task automatic wait_rx(input int target, input int budget);
    int c = 0;
    while (rx_n < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq("rx_wait", rx_n >= target, 1);
  endtask

  int         base_r, base_f, base_d, base_e;
  int         n, c;
  logic [7:0] exp_b [0:7];

  initial begin
    // Single 0x55 frame, cycle by cycle, then empty-buffer retry cadence.
    do_reset();
    base_r = rx_n; base_d = dre_n;
    push(8'h55);
    enable = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      check_eq("s1_txd", txd, exp_txd(8'h55, i - 3));
      check_eq("s1_dre", rd.dataReadEnable, (i == 1 || i == 3 + FrameLen));
      check_eq("s1_busy", busy, (i <= 4 + FrameLen));
      check_eq("s1_sent", bytesSent, (i >= 3 + FrameLen));
    end
    wait_t(3 + FrameLen + 2 * Period + 2);
    check_eq("s1_dre_count", dre_n - base_d, 4);
    check_eq("s1_dre0", dre_mem[base_d], 1);
    for (int k = 1; k < 4; k++)
      check_eq("s1_dre_retry", dre_mem[base_d + k], 3 + FrameLen + (k - 1) * Period);
    check_eq("s1_rx", rx_mem[base_r], 8'h55);
    check_eq("s1_txd_idle", txd, 1);
    check_eq("s1_sent_final", bytesSent, 1);

    // Refused first read (same-cycle write won), retry delivers the byte once.
    do_reset();
    base_r = rx_n; base_f = fall_n; base_d = dre_n;
    push(8'hC3);
    coll_req = coll_used + 1;
    enable = 1'b1;
    wait_rx(base_r + 1, 300);
    repeat (30) @(negedge clk);
    check_eq("s2_rx_count", rx_n - base_r, 1);
    check_eq("s2_rx", rx_mem[base_r], 8'hC3);
    check_eq("s2_sent", bytesSent, 1);
    check_eq("s2_dre_retry", dre_mem[base_d + 1], 1 + Period);
    check_eq("s2_fall", fall_mem[base_f], 3 + Period);
    check_eq("s2_empty", bwp - brp, 0);

    // Back-to-back frames with enable held.
    do_reset();
    base_r = rx_n; base_f = fall_n; base_e = ferr;
    push(8'h01); push(8'h80); push(8'hA5);
    exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'hA5;
    enable = 1'b1;
    wait_rx(base_r + 3, 1000);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("s3_rx", rx_mem[base_r + k], exp_b[k]);
      check_eq("s3_fall", fall_mem[base_f + k], 3 + k * Gap);
    end
    check_eq("s3_sent", bytesSent, 3);
    check_eq("s3_empty", bwp - brp, 0);
    check_eq("s3_ferr", ferr - base_e, 0);

    // Reset during data bit 3 of 0xA5; the following byte goes out intact.
    do_reset();
    base_r = rx_n; base_f = fall_n; base_e = ferr;
    push(8'hA5); push(8'h5A);
    enable = 1'b1;
    wait_t(3 + 4 * Cpb);
    reset = 1'b1;
    @(negedge clk);
    check_eq("s4_rst_txd", txd, 1);
    check_eq("s4_rst_busy", busy, 0);
    check_eq("s4_rst_sent", bytesSent, 0);
    reset = 1'b0;
    wait_rx(base_r + 1, 300);
    repeat (4) @(negedge clk);
    check_eq("s4_rx_count", rx_n - base_r, 1);
    check_eq("s4_rx", rx_mem[base_r], 8'h5A);
    check_eq("s4_fall", fall_mem[base_f + 1], 3);
    check_eq("s4_sent", bytesSent, 1);
    check_eq("s4_ferr", ferr - base_e, 0);

    // enable dropped during the start bit: frame completes, then idles.
    do_reset();
    base_r = rx_n; base_d = dre_n;
    push(8'h3C); push(8'h11);
    enable = 1'b1;
    wait_t(5);
    enable = 1'b0;
    wait_t(80);
    check_eq("s5_rx_count", rx_n - base_r, 1);
    check_eq("s5_rx", rx_mem[base_r], 8'h3C);
    check_eq("s5_sent", bytesSent, 1);
    check_eq("s5_dre_count", dre_n - base_d, 1);
    check_eq("s5_left", bwp - brp, 1);
    check_eq("s5_busy", busy, 0);
    enable = 1'b1;
    wait_rx(base_r + 2, 300);
    repeat (4) @(negedge clk);
    check_eq("s5_rx2", rx_mem[base_r + 1], 8'h11);
    check_eq("s5_sent2", bytesSent, 2);
    enable = 1'b0;

    // Random bursts with a random number of leading refused reads.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      base_r = rx_n; base_f = fall_n; base_e = ferr;
      n = $urandom_range(3, 6);
      c = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        exp_b[k] = 8'($urandom);
        push(exp_b[k]);
      end
      coll_req = coll_used + c;
      enable = 1'b1;
      wait_rx(base_r + n, 2000);
      repeat (4) @(negedge clk);
      for (int k = 0; k < n; k++) begin
        check_eq("s6_rx", rx_mem[base_r + k], exp_b[k]);
        check_eq("s6_fall", fall_mem[base_f + k], 3 + c * Period + k * Gap);
      end
      check_eq("s6_sent", bytesSent, n);
      check_eq("s6_ferr", ferr - base_e, 0);
      enable = 1'b0;
    end

    check_eq("dre_consec", consec, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
